// File: rtl/i2c_wr_queue_pkg.sv
// Shared definitions for the EEPROM write-staging queue: FSM encoding,
// default timing/address constants and the address-advance helper.
package i2c_wr_queue_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_END = 2'd2,
    ST_WAIT_TWR = 2'd3
  } wr_state_e;

  localparam logic [15:0] DEF_ADDR_MAX = 16'h03FF;
  localparam logic [17:0] DEF_TWR_CYC  = 18'd250_000;

  // Next EEPROM byte address; the last valid address rolls over to zero.
  function automatic logic [15:0] next_addr(input logic [15:0] addr,
                                            input logic [15:0] addr_max);
    logic [15:0] nxt;
    if (addr >= addr_max) begin
      nxt = 16'h0000;
    end else begin
      nxt = addr + 16'h0001;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/i2c_wr_queue_wr_fifo.sv
// Synchronous byte FIFO with first-word-visible read data; a push while
// full and a pop while empty are both ignored.
module wr_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign data_o    = mem_q[rd_ptr_q];

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push_ok_s && !pop_ok_s) begin
        count_q <= count_q + CW'(1);
      end else if (pop_ok_s && !push_ok_s) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_wr_queue.sv
// Write-staging stage in front of the I2C controller: buffers producer bytes and
// drains them as single-byte EEPROM writes to auto-incrementing addresses, pacing each by tWR.
module i2c_wr_queue
  import i2c_wr_queue_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter logic [15:0] ADDR_MAX   = DEF_ADDR_MAX,
  parameter logic [17:0] TWR_CYC    = DEF_TWR_CYC
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        addr_load,
  input  logic [15:0] base_addr,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        i2c_start,
  output logic        wr_en,
  output logic        rd_en,
  output logic [15:0] byte_addr,
  output logic [7:0]  wr_data,
  input  logic        i2c_end,
  output logic        busy,
  output logic [15:0] wr_cnt
);

  wr_state_e   state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [17:0] twr_q, twr_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] byte_addr_q, byte_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        i2c_start_q, i2c_start_d;
  logic        wr_en_q, wr_en_d;
  logic        busy_q;

  logic        fifo_pop_s;
  logic [7:0]  fifo_rd_data_s;
  logic        fifo_full_s;
  logic        fifo_empty_s;
  logic        twr_done_s;

  wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .push_i  (in_valid),
    .data_i  (in_data),
    .pop_i   (fifo_pop_s),
    .data_o  (fifo_rd_data_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Widened compare keeps TWR_CYC=0 from underflowing into a huge wait.
  assign twr_done_s = ({1'b0, twr_q} + 19'd1) >= {1'b0, TWR_CYC};

  // Next-state, counter and output-register logic of the write pacer.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    twr_d       = twr_q;
    wr_cnt_d    = wr_cnt_q;
    byte_addr_d = byte_addr_q;
    wr_data_d   = wr_data_q;
    i2c_start_d = i2c_start_q;
    wr_en_d     = wr_en_q;
    fifo_pop_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (addr_load) begin
          addr_d = (base_addr > ADDR_MAX) ? 16'h0000 : base_addr;
        end else if (!fifo_empty_s) begin
          fifo_pop_s  = 1'b1;
          wr_data_d   = fifo_rd_data_s;
          byte_addr_d = addr_q;
          state_d     = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        i2c_start_d = 1'b1;
        wr_en_d     = 1'b1;
        state_d     = ST_WAIT_END;
      end
      ST_WAIT_END: begin
        if (i2c_end) begin
          i2c_start_d = 1'b0;
          wr_en_d     = 1'b0;
          wr_cnt_d    = wr_cnt_q + 16'd1;
          addr_d      = next_addr(addr_q, ADDR_MAX);
          twr_d       = 18'd0;
          state_d     = ST_WAIT_TWR;
        end else begin
          state_d = ST_WAIT_END;
        end
      end
      ST_WAIT_TWR: begin
        if (twr_done_s) begin
          state_d = ST_IDLE;
        end else begin
          twr_d = twr_q + 18'd1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        i2c_start_d = 1'b0;
        wr_en_d     = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= 16'h0000;
      twr_q       <= 18'd0;
      wr_cnt_q    <= 16'h0000;
      byte_addr_q <= 16'h0000;
      wr_data_q   <= 8'h00;
      i2c_start_q <= 1'b0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      twr_q       <= twr_d;
      wr_cnt_q    <= wr_cnt_d;
      byte_addr_q <= byte_addr_d;
      wr_data_q   <= wr_data_d;
      i2c_start_q <= i2c_start_d;
      wr_en_q     <= wr_en_d;
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign in_ready  = ~fifo_full_s;
  assign i2c_start = i2c_start_q;
  assign wr_en     = wr_en_q;
  assign rd_en     = 1'b0;
  assign byte_addr = byte_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_i2c_wr_queue.sv
// Randomized scoreboard bench for i2c_wr_queue with a behavioural I2C controller stub.
module tb_i2c_wr_queue;

  localparam int          TWR   = 20;
  localparam logic [15:0] AMAX  = 16'h03FF;
  localparam int          DEPTH = 16;

  logic        sys_clk, sys_rst_n, addr_load, in_valid, in_ready;
  logic [15:0] base_addr, byte_addr, wr_cnt;
  logic [7:0]  in_data, wr_data;
  logic        i2c_start, wr_en, rd_en, i2c_end, busy;

  i2c_wr_queue #(.FIFO_DEPTH(DEPTH), .ADDR_MAX(AMAX), .TWR_CYC(18'd20)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .addr_load(addr_load), .base_addr(base_addr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .i2c_start(i2c_start),
    .wr_en(wr_en), .rd_en(rd_en), .byte_addr(byte_addr), .wr_data(wr_data),
    .i2c_end(i2c_end), .busy(busy), .wr_cnt(wr_cnt)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          push_cyc;
    bit          idle;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_addr;
  int          pushed_total, ended_total, last_end_cyc;
  int          cyc, total, bad;
  bit          stall, prev_start;
  logic [15:0] cur_addr;
  logic [7:0]  cur_data;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", nm, cyc);
  endtask

  function automatic logic [15:0] model_next(input logic [15:0] a);
    return (a == AMAX) ? 16'h0000 : a + 16'h0001;
  endfunction

  // Offer one byte; returns once it has been accepted or the wait has expired.
  task automatic push_byte(input logic [7:0] d, output bit ok);
    exp_t e;
    ok = 1'b0;
    @(negedge sys_clk);
    in_valid = 1'b1;
    in_data  = d;
    for (int g = 0; g < 200; g++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    if (ok) begin
      e.addr     = model_addr;
      e.data     = d;
      e.push_cyc = cyc;
      e.idle     = (pushed_total == ended_total) && (cyc >= last_end_cyc + TWR + 1);
      exp_q.push_back(e);
      model_addr = model_next(model_addr);
      pushed_total++;
      @(posedge sys_clk);
      #1;
    end else begin
      fail_now("push_timeout");
    end
    in_valid = 1'b0;
  endtask

  task automatic load_addr(input logic [15:0] a);
    @(negedge sys_clk);
    addr_load = 1'b1;
    base_addr = a;
    @(negedge sys_clk);
    addr_load = 1'b0;
    model_addr = (a > AMAX) ? 16'h0000 : a;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (pushed_total != ended_total && g < 4000) begin
      @(negedge sys_clk);
      g++;
    end
    if (g >= 4000) fail_now("drain_timeout");
    repeat (TWR + 5) @(negedge sys_clk);
  endtask

  task automatic wait_start();
    int g;
    g = 0;
    while (!i2c_start && g < 200) begin
      @(negedge sys_clk);
      g++;
    end
    if (g >= 200) fail_now("start_timeout");
  endtask

  // Controller stub: i2c_end one cycle wide, 40 cycles after i2c_start, held off by stall.
  initial begin
    i2c_end = 1'b0;
    forever begin
      @(negedge sys_clk);
      if (i2c_start && sys_rst_n) begin
        for (int n = 0; n < 40 && i2c_start; n++) @(negedge sys_clk);
        for (int g = 0; g < 5000 && stall && i2c_start; g++) @(negedge sys_clk);
        if (i2c_start) begin
          i2c_end = 1'b1;
          last_end_cyc = cyc;
          ended_total++;
          @(negedge sys_clk);
          i2c_end = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every new write request and checks pacing.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prev_start = 1'b0;
    end else begin
      if (i2c_start && !prev_start) begin
        if (exp_q.size() == 0) begin
          fail_now("spurious_i2c_start");
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("write_addr", {16'h0, byte_addr}, {16'h0, e.addr});
          check("write_data", {24'h0, wr_data}, {24'h0, e.data});
          check("write_wr_en", {31'h0, wr_en}, 32'd1);
          cur_addr = byte_addr;
          cur_data = wr_data;
          if (e.push_cyc <= last_end_cyc + TWR) begin
            check("gap_end_to_start", cyc - last_end_cyc, TWR + 3);
          end else if (e.idle) begin
            check("latency_push_to_start", cyc - e.push_cyc, 32'd3);
          end
        end
      end else if (i2c_start) begin
        check("hold_addr", {16'h0, byte_addr}, {16'h0, cur_addr});
        check("hold_data", {24'h0, wr_data}, {24'h0, cur_data});
      end
      if (cyc == last_end_cyc + 1) begin
        check("wr_cnt_after_end", {16'h0, wr_cnt}, ended_total);
        check("start_drop_after_end", {31'h0, i2c_start}, 32'd0);
        check("wr_en_drop_after_end", {31'h0, wr_en}, 32'd0);
      end
      if (cyc == last_end_cyc + TWR) check("busy_during_twr", {31'h0, busy}, 32'd1);
      if (cyc == last_end_cyc + TWR + 1) check("busy_after_twr", {31'h0, busy}, 32'd0);
      prev_start = i2c_start;
    end
  end

  initial begin
    bit ok;
    int acc;
    total = 0; bad = 0;
    pushed_total = 0; ended_total = 0; last_end_cyc = -1000;
    model_addr = 16'h0000; stall = 1'b0; prev_start = 1'b0;
    sys_rst_n = 1'b0; addr_load = 1'b0; base_addr = 16'h0000;
    in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    check("rst_i2c_start", {31'h0, i2c_start}, 32'd0);
    check("rst_wr_en", {31'h0, wr_en}, 32'd0);
    check("rst_rd_en", {31'h0, rd_en}, 32'd0);
    check("rst_byte_addr", {16'h0, byte_addr}, 32'd0);
    check("rst_wr_data", {24'h0, wr_data}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_wr_cnt", {16'h0, wr_cnt}, 32'd0);
    check("rst_in_ready", {31'h0, in_ready}, 32'd1);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Single write from a loaded base address.
    load_addr(16'h0010);
    push_byte(8'hA5, ok);
    wait_drain();
    check("wr_cnt_single", {16'h0, wr_cnt}, 32'd1);

    // Three back-to-back bytes.
    load_addr(16'h0010);
    push_byte(8'h01, ok);
    push_byte(8'h02, ok);
    push_byte(8'h03, ok);
    wait_drain();
    check("wr_cnt_three", {16'h0, wr_cnt}, 32'd4);

    // Fill while the controller stalls: 17 accepted, then back-pressure.
    stall = 1'b1;
    acc = 0;
    for (int i = 0; i < 17; i++) begin
      push_byte(8'($urandom_range(0, 255)), ok);
      if (ok) acc++;
    end
    check("accepted_before_full", acc, 32'd17);
    @(negedge sys_clk);
    check("in_ready_full", {31'h0, in_ready}, 32'd0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    repeat (3) begin
      @(negedge sys_clk);
      check("in_ready_held_low", {31'h0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    stall = 1'b0;
    wait_drain();
    check("wr_cnt_fill", {16'h0, wr_cnt}, 32'd21);

    // Address wrap at ADDR_MAX and out-of-range base.
    load_addr(AMAX);
    push_byte(8'h5A, ok);
    push_byte(8'hC3, ok);
    wait_drain();
    load_addr(16'h8000);
    push_byte(8'h77, ok);
    wait_drain();

    // addr_load during WAIT_END is ignored.
    load_addr(16'h0100);
    push_byte(8'h11, ok);
    wait_start();
    repeat (2) @(negedge sys_clk);
    addr_load = 1'b1;
    base_addr = 16'h0200;
    @(negedge sys_clk);
    addr_load = 1'b0;
    push_byte(8'h22, ok);
    wait_drain();

    // Random bytes with random spacing.
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 30)) @(negedge sys_clk);
      push_byte(8'($urandom_range(0, 255)), ok);
    end
    wait_drain();
    check("wr_cnt_random", {16'h0, wr_cnt}, ended_total);

    // Reset in the middle of WAIT_END with bytes still queued.
    push_byte(8'h31, ok);
    push_byte(8'h32, ok);
    push_byte(8'h33, ok);
    wait_start();
    repeat (5) @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    exp_q.delete();
    pushed_total = 0; ended_total = 0; last_end_cyc = -1000; model_addr = 16'h0000;
    #1;
    check("rst_async_start", {31'h0, i2c_start}, 32'd0);
    check("rst_async_busy", {31'h0, busy}, 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("post_rst_wr_cnt", {16'h0, wr_cnt}, 32'd0);
    check("post_rst_in_ready", {31'h0, in_ready}, 32'd1);
    check("post_rst_byte_addr", {16'h0, byte_addr}, 32'd0);
    repeat (60) @(negedge sys_clk);
    check("post_rst_no_start", {31'h0, i2c_start}, 32'd0);
    push_byte(8'h99, ok);
    wait_drain();
    check("wr_cnt_after_reset", {16'h0, wr_cnt}, 32'd1);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
